duart_rx_channel: RTL
=====================

// Module: duart_rx_channel
// PURPOSE
//  Receive channel feeding one DUART port (channel A or B).
//  Samples the serial RX line and deframes 8N1 characters (LSB first).
//  Queues each character plus its framing-error bit in a small FIFO, as the 2681 does.
//  Presents head-of-FIFO data and status flags to the DUART register file, which pops on RHR read.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per bit; minimum 8.
//  FIFO_DEPTH    4    entries; power of two, at least 2.
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-low reset
//  rx_enable    in   1  1 = receiver enabled
//  rxd          in   1  serial input, idles high; asynchronous to clk
//  pop          in   1  one-cycle strobe: remove head entry (RHR read)
//  err_reset    in   1  one-cycle strobe: clear overrun
//  rx_data      out  8  head entry data; 8'h00 when FIFO empty
//  rx_fe        out  1  head entry framing error; 0 when empty
//  rx_rdy       out  1  FIFO not empty
//  ffull        out  1  FIFO holds FIFO_DEPTH entries
//  overrun      out  1  sticky: a character was lost
// BEHAVIOUR
//  Reset: all outputs 0; pointers and count 0; FSM in IDLE; synchroniser flops preset to 1.
//  Input path: rxd passes through a 2-flop synchroniser (rs); all decisions use rs.
//  Sampling: majority of rs at the centre cycle C and cycles C-1 and C-2.
//  FSM states: IDLE, START, DATA, STOP, BRK.
//   IDLE: a falling edge on rs while rx_enable=1 -> START; clear the cycle counter.
//   START: at cycle CLKS_PER_BIT/2 (centre), take the majority sample.
//    Sample 1 -> IDLE (false start). Sample 0 -> DATA, bit index 0.
//   DATA: each bit centre is the previous centre + CLKS_PER_BIT.
//    Shift the majority sample into bit[index]. After index 7 -> STOP.
//   STOP: at the stop-bit centre, push {fe, data}, where fe = ~sample.
//    fe=0 -> IDLE. fe=1 -> BRK.
//   BRK: wait for rs=1, then -> IDLE. A held break yields exactly one entry.
//  rx_enable=0: FSM forced to IDLE at once; a partial character is discarded.
//   FIFO, pop and flags keep operating.
//  FIFO behaviour:
//   Push: write at wr_ptr. Pointers wrap modulo FIFO_DEPTH.
//   Flags are registered: rx_rdy/ffull/rx_data/rx_fe update on the cycle after a push or pop.
//   Latency: rx_rdy rises 1 clk after the stop-centre cycle.
//   Pop when empty: ignored. No pointer or flag change.
//   Push when full with no pop: character discarded, FIFO unchanged, overrun <= 1.
//   Push and pop in the same cycle when full: both performed; count unchanged; no overrun.
//   Push and pop in the same cycle when empty: push only; the pop is ignored.
//   overrun: set as above; cleared by err_reset. Set wins if both occur in the same cycle.
//  Reset asserted mid-character: asynchronous return to the reset state; the partial character is lost.
// TESTING (bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4)
//  1. Send 8'h55 with a good stop bit.
//     -> rx_rdy=1 one clk after the stop centre; rx_data=8'h55, rx_fe=0.
//     -> pop -> rx_rdy=0 and rx_data=8'h00 the next cycle.
//  2. Drive rxd low for 4 clks, then high.
//     -> no push; FSM back in IDLE; rx_rdy stays 0.
//  3. Send 8'hA1..8'hA5 with no pops.
//     -> ffull=1 after 8'hA4; overrun=1 after 8'hA5.
//     -> pops return A1, A2, A3, A4, then rx_rdy=0.
//     -> err_reset -> overrun=0.
//  4. Hold rxd low for 30 bit times (break).
//     -> exactly one entry {fe=1, 8'h00}.
//     -> after rxd returns high, 8'h3C is received correctly.
//  5. Send 8'hF0 with rxd inverted for 1 clk at the bit-3 centre.
//     -> majority vote yields rx_data=8'hF0.
//  6. Assert reset at data bit 4 of a character.
//     -> all outputs 0 immediately.
//     -> after release, 8'h81 is received correctly.

Source files
------------

// File: rtl/duart_rx_channel.sv
// rtl/duart_rx_channel.sv - DUART receive channel: 8N1 deframer with majority sampling and status FIFO
module duart_rx_channel #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_enable,
   input  logic       rxd,
   input  logic       pop,
   input  logic       err_reset,
   output logic [7:0] rx_data,
   output logic       rx_fe,
   output logic       rx_rdy,
   output logic       ffull,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int NW = PW + 1;
   localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] DEPTH = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t          state_q;
   logic            rs1_q, rs_q;
   logic [1:0]      hist_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      idx_q;
   logic [7:0]      shift_q;

   logic [8:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]   count_q, count_d;
   logic [7:0]      rx_data_q;
   logic            rx_fe_q, rx_rdy_q, ffull_q, overrun_q, overrun_d;
   logic [8:0]      head_d;

   logic            maj, fall, push, pop_ok, push_ok, ovr_set, full;
   logic [8:0]      push_word;

   // hist_q[0] holds rs from the previous cycle, hist_q[1] from two cycles back
   always_comb begin
      maj       = (rs_q & hist_q[0]) | (rs_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
      fall      = hist_q[0] & ~rs_q;
      push      = rx_enable && (state_q == STOP) && (cnt_q == LAST);
      push_word = {~maj, shift_q};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rs1_q   <= 1'b1;
         rs_q    <= 1'b1;
         hist_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         rs1_q  <= rxd;
         rs_q   <= rs1_q;
         hist_q <= {hist_q[0], rs_q};
         if (!rx_enable) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (fall) begin
                     state_q <= START;
                     cnt_q   <= '0;
                  end
               end
               START: begin
                  if (cnt_q == HALF) begin
                     cnt_q <= '0;
                     idx_q <= '0;
                     state_q <= maj ? IDLE : DATA;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               DATA: begin
                  if (cnt_q == LAST) begin
                     cnt_q          <= '0;
                     shift_q[idx_q] <= maj;
                     if (idx_q == 3'd7) state_q <= STOP;
                     else               idx_q   <= idx_q + 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               STOP: begin
                  if (cnt_q == LAST) begin
                     cnt_q   <= '0;
                     state_q <= maj ? IDLE : BRK;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               BRK: begin
                  if (rs_q) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // A pop on an empty FIFO is dropped, so a same-cycle push into an empty FIFO wins
   always_comb begin
      full     = (count_q == DEPTH);
      pop_ok   = pop && (count_q != '0);
      push_ok  = push && (!full || pop_ok);
      ovr_set  = push && full && !pop_ok;
      wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + NW'(push_ok) - NW'(pop_ok);
      head_d   = 9'h000;
      if (count_d != '0) begin
         if (push_ok && (count_q == '0)) head_d = push_word;
         else                            head_d = mem_q[rd_ptr_d];
      end
      overrun_d = overrun_q;
      if (err_reset) overrun_d = 1'b0;
      if (ovr_set)   overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_word;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rx_data_q <= '0;
         rx_fe_q   <= 1'b0;
         rx_rdy_q  <= 1'b0;
         ffull_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rx_data_q <= head_d[7:0];
         rx_fe_q   <= head_d[8];
         rx_rdy_q  <= (count_d != '0);
         ffull_q   <= (count_d == DEPTH);
         overrun_q <= overrun_d;
      end
   end

   assign rx_data = rx_data_q;
   assign rx_fe   = rx_fe_q;
   assign rx_rdy  = rx_rdy_q;
   assign ffull   = ffull_q;
   assign overrun = overrun_q;

endmodule
